// File: rtl/simon_disp_pkg.sv
// Shared display definitions for the Simon Says game: glyph codes, stage
// encodings and the right-justified text lookup used by the countdown banner.
package simon_disp_pkg;

    localparam logic [3:0] GLYPH_R    = 4'hA;
    localparam logic [3:0] GLYPH_D    = 4'h4;
    localparam logic [3:0] GLYPH_Y    = 4'hC;
    localparam logic [3:0] GLYPH_S    = 4'hB;
    localparam logic [3:0] GLYPH_E    = 4'hE;
    localparam logic [3:0] GLYPH_T    = 4'h7;
    localparam logic [3:0] GLYPH_G    = 4'h6;
    localparam logic [3:0] GLYPH_O    = 4'h0;
    localparam logic [3:0] GLYPH_NONE = 4'h0;

    typedef enum logic [2:0] {
        STAGE_IDLE  = 3'd0,
        STAGE_READY = 3'd1,
        STAGE_SET   = 3'd2,
        STAGE_GO    = 3'd3
    } stage_e;

    // Returns {blank, code} for digit position pos (0 = rightmost) of the
    // banner text shown in stage st; positions left of the text are dark.
    function automatic logic [4:0] glyph_at(input stage_e st, input int unsigned pos);
        logic [4:0] res;
        res = {1'b1, GLYPH_NONE};
        case (st)
            STAGE_READY: begin
                case (pos)
                    0:       res = {1'b0, GLYPH_Y};
                    1:       res = {1'b0, GLYPH_D};
                    2:       res = {1'b0, GLYPH_R};
                    default: res = {1'b1, GLYPH_NONE};
                endcase
            end
            STAGE_SET: begin
                case (pos)
                    0:       res = {1'b0, GLYPH_T};
                    1:       res = {1'b0, GLYPH_E};
                    2:       res = {1'b0, GLYPH_S};
                    default: res = {1'b1, GLYPH_NONE};
                endcase
            end
            STAGE_GO: begin
                case (pos)
                    0:       res = {1'b0, GLYPH_O};
                    1:       res = {1'b0, GLYPH_G};
                    default: res = {1'b1, GLYPH_NONE};
                endcase
            end
            default: res = {1'b1, GLYPH_NONE};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running clock divider producing a one-cycle tick every DIV cycles;
// clr restarts the period so the first tick lands DIV cycles later.
module tick_divider #(
    parameter int DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_banner.sv
// "rdY / SEt / Go" countdown sequencer: steps READY -> SET -> GO on start,
// drives right-justified glyphs for the seven-segment mux and go/done pulses.
module countdown_banner
    import simon_disp_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int TICK_DIV         = 50_000_000,
    parameter int STAGE_TICKS      = 2,
    parameter int GO_TICKS         = 1,
    parameter int RESTART_ON_START = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic [2:0]              stage,
    output logic                    busy,
    output logic                    go,
    output logic                    done
);

    localparam int MAX_TICKS = (STAGE_TICKS > GO_TICKS) ? STAGE_TICKS : GO_TICKS;
    localparam int TW        = $clog2(MAX_TICKS) + 1;
    localparam logic [TW-1:0] STAGE_LAST = TW'(STAGE_TICKS - 1);
    localparam logic [TW-1:0] GO_LAST    = TW'(GO_TICKS - 1);

    stage_e                  state_q, state_d;
    logic [TW-1:0]           tcnt_q, tcnt_d;
    logic                    busy_q, busy_d;
    logic                    go_q, go_d;
    logic                    done_q, done_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic                    div_clr;
    logic                    tick;
    logic                    start_ok;
    logic [TW-1:0]           tcnt_last;

    tick_divider #(
        .DIV (TICK_DIV)
    ) u_tick_divider (
        .clk   (clk),
        .reset (reset),
        .clr   (div_clr),
        .tick  (tick)
    );

    assign start_ok  = start && ((state_q == STAGE_IDLE) || (RESTART_ON_START != 0));
    assign tcnt_last = (state_q == STAGE_GO) ? GO_LAST : STAGE_LAST;

    // Abort has priority over start, including a simultaneous start in IDLE.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        div_clr = 1'b0;
        if (abort) begin
            state_d = STAGE_IDLE;
            tcnt_d  = '0;
        end else if (start_ok) begin
            state_d = STAGE_READY;
            tcnt_d  = '0;
            div_clr = 1'b1;
        end else if ((state_q != STAGE_IDLE) && tick) begin
            if (tcnt_q == tcnt_last) begin
                tcnt_d = '0;
                case (state_q)
                    STAGE_READY: state_d = STAGE_SET;
                    STAGE_SET:   state_d = STAGE_GO;
                    default:     state_d = STAGE_IDLE;
                endcase
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end
    end

    assign busy_d = (state_d != STAGE_IDLE);
    assign go_d   = (state_d == STAGE_GO) && (state_q != STAGE_GO);
    assign done_d = (state_q == STAGE_GO) && (state_d == STAGE_IDLE) && !abort;

    // Display encoding is computed from the next state so glyphs and stage
    // change on the same edge.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign {blank_d[gi], digits_d[4*gi +: 4]} = glyph_at(state_d, gi);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= STAGE_IDLE;
            tcnt_q   <= '0;
            busy_q   <= 1'b0;
            go_q     <= 1'b0;
            done_q   <= 1'b0;
            digits_q <= '0;
            blank_q  <= '1;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            busy_q   <= busy_d;
            go_q     <= go_d;
            done_q   <= done_d;
            digits_q <= digits_d;
            blank_q  <= blank_d;
        end
    end

    assign stage  = state_q;
    assign busy   = busy_q;
    assign go     = go_q;
    assign done   = done_q;
    assign digits = digits_q;
    assign blank  = blank_q;

endmodule
